z80_io_write_fifo: RTL and testbench

- Consumes Z80 I/O write cycles on the snooped bus and queues each one as a {port, data} entry for the FujiNet host-side logic.
- Sits directly downstream of the bus-snoop address capture stage, on the same Z80 pins (IORQ_n, WR_n, A[7:0], D[7:0]).
- Synchronises the strobes, samples address and data at a fixed point mid-cycle, and pushes the result into a synchronous FIFO.
- The consumer drains the FIFO with a valid/read-enable handshake.

---
 rtl/z80_io_write_fifo.sv | 189 ++++++++++++++++++
 tb/tb_z80_io_write_fifo.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/z80_io_write_fifo.sv
// z80_io_write_fifo
// Snoops Z80 I/O write cycles (IORQ_n & WR_n low), samples {port, data} at a
// fixed delay after the synchronised strobe assertion, and queues the pair in
// a first-word-fall-through FIFO for the host-side consumer.
// Optional feature macro: IO_PORT_FILTER_EN. When defined, only ports with
// (addr & PORT_MASK) == (PORT_BASE & PORT_MASK) are queued.
//
// Consumer handshake: rd_valid high means rd_data holds the oldest entry.
// An entry is consumed on a clk edge where rd_en and rd_valid are both high.
// rd_en while rd_valid is low has no effect.
module z80_io_write_fifo #(
  parameter int         SYNC_STAGES = 2,
  parameter int         SAMPLE_DLY  = 6,
  parameter int         DEPTH_LOG2  = 4,
  parameter logic [7:0] PORT_BASE   = 8'hE0,
  parameter logic [7:0] PORT_MASK   = 8'hF0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  z80_iorq_n,
  input  logic                  z80_wr_n,
  input  logic [7:0]            z80_addr,
  input  logic [7:0]            z80_data,
  input  logic                  rd_en,
  output logic [15:0]           rd_data,
  output logic                  rd_valid,
  output logic [DEPTH_LOG2:0]   fill,
  output logic                  overflow,
  input  logic                  ovf_clr,
  output logic                  short_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  // Synchroniser chains (index SYNC_STAGES-1 is the synchronised output)
  logic [SYNC_STAGES-1:0] iorq_sync_q, iorq_sync_d;
  logic [SYNC_STAGES-1:0] wr_sync_q, wr_sync_d;
  // Tracks how many stages have refilled from the pins since reset
  logic [SYNC_STAGES-1:0] sync_vld_q, sync_vld_d;
  logic                   act;
  logic                   act_prev_q, act_prev_d;
  // Set once the strobe has been seen idle after reset, so a cycle already
  // in progress when reset released is never captured
  logic                   armed_q, armed_d;

  state_t                 state_q, state_d;
  logic [7:0]             cnt_q, cnt_d;
  logic                   push_req;
  logic                   port_ok;

  logic [15:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0]  wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0]  rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]    fill_q, fill_d;
  logic                   overflow_q, overflow_d;
  logic                   full;
  logic                   do_push;
  logic                   do_pop;
  logic                   ovf_set;

  // Synchroniser shift, arming and previous-strobe tracking
  always_comb begin
    iorq_sync_d = {iorq_sync_q[SYNC_STAGES-2:0], z80_iorq_n};
    wr_sync_d   = {wr_sync_q[SYNC_STAGES-2:0], z80_wr_n};
    sync_vld_d  = {sync_vld_q[SYNC_STAGES-2:0], 1'b1};
    act         = ~iorq_sync_q[SYNC_STAGES-1] & ~wr_sync_q[SYNC_STAGES-1];
    act_prev_d  = act;
    armed_d     = armed_q | (sync_vld_q[SYNC_STAGES-1] & ~act);
  end

  // Port filter: every write qualifies unless filtering is built in
`ifdef IO_PORT_FILTER_EN
  assign port_ok = ((z80_addr & PORT_MASK) == (PORT_BASE & PORT_MASK));
`else
  assign port_ok = 1'b1;
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next-state: arm on strobe rise, count to sample point, hold till end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (act && !act_prev_q && armed_q) begin
          state_d = ST_WAIT;
          cnt_d   = 8'd1;
        end
      end
      ST_WAIT: begin
        if (!act) begin
          state_d = ST_IDLE;
        end else if (cnt_q == 8'(SAMPLE_DLY)) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_SAMPLE: state_d = ST_HOLD;
      ST_HOLD: begin
        if (!act) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: push request at the sample point, short-cycle pulse
  always_comb begin
    push_req  = 1'b0;
    short_err = 1'b0;
    case (state_q)
      ST_WAIT:   short_err = ~act;
      ST_SAMPLE: push_req  = port_ok;
      default: begin
        push_req  = 1'b0;
        short_err = 1'b0;
      end
    endcase
  end

  // FIFO control: pop only when non-empty; push into a full FIFO only if a
  // pop frees a slot in the same cycle, otherwise drop and flag overflow
  always_comb begin
    full       = (fill_q == (DEPTH_LOG2+1)'(DEPTH));
    do_pop     = rd_en & (fill_q != '0);
    do_push    = push_req & (~full | do_pop);
    ovf_set    = push_req & full & ~do_pop;
    wr_ptr_d   = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    fill_d     = fill_q;
    if (do_push && !do_pop) fill_d = fill_q + 1'b1;
    if (!do_push && do_pop) fill_d = fill_q - 1'b1;
    overflow_d = ovf_set ? 1'b1 : (ovf_clr ? 1'b0 : overflow_q);
  end

  // Synchroniser, arming and FIFO bookkeeping registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      iorq_sync_q <= '1;
      wr_sync_q   <= '1;
      sync_vld_q  <= '0;
      act_prev_q  <= 1'b0;
      armed_q     <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
      overflow_q  <= 1'b0;
    end else begin
      iorq_sync_q <= iorq_sync_d;
      wr_sync_q   <= wr_sync_d;
      sync_vld_q  <= sync_vld_d;
      act_prev_q  <= act_prev_d;
      armed_q     <= armed_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fill_q      <= fill_d;
      overflow_q  <= overflow_d;
    end
  end

  // Entry storage: address and data lines are stable mid-cycle, so they are
  // captured straight from the bus without synchronisation
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= {z80_addr, z80_data};
  end

  assign rd_valid = (fill_q != '0);
  assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : 16'h0000;
  assign fill     = fill_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_z80_io_write_fifo.sv
// Directed testbench for z80_io_write_fifo (default parameters).
// Build with +define+IO_PORT_FILTER_EN to exercise the port filter.
module tb_z80_io_write_fifo;

  logic        clk;
  logic        rst_n;
  logic        z80_iorq_n;
  logic        z80_wr_n;
  logic [7:0]  z80_addr;
  logic [7:0]  z80_data;
  logic        rd_en;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic [4:0]  fill;
  logic        overflow;
  logic        ovf_clr;
  logic        short_err;

  int checks;
  int errors;
  int short_cnt;

  z80_io_write_fifo dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .z80_iorq_n(z80_iorq_n),
    .z80_wr_n  (z80_wr_n),
    .z80_addr  (z80_addr),
    .z80_data  (z80_data),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .fill      (fill),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr),
    .short_err (short_err)
  );

  // Clock and pulse monitor
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (short_err === 1'b1) short_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
  endtask

  // One OUT cycle: strobes low for hold clks, then idle for a few clks
  task automatic io_write(input logic [7:0] port, input logic [7:0] dat, input int hold);
    @(posedge clk); #1;
    z80_addr   = port;
    z80_data   = dat;
    z80_iorq_n = 1'b0;
    z80_wr_n   = 1'b0;
    repeat (hold) @(posedge clk);
    #1;
    z80_iorq_n = 1'b1;
    z80_wr_n   = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Check head entry, then pop it
  task automatic pop_check(input string name, input logic [15:0] exp);
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== exp) begin
      errors++;
      $display("FAIL %s: rd_valid=%b rd_data=%h expected rd_valid=1 rd_data=%h",
               name, rd_valid, rd_data, exp);
    end
    rd_en = 1'b1;
    @(posedge clk); #1;
    rd_en = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    checks++;
    if (rd_valid !== 1'b0 || fill !== 5'd0 || overflow !== 1'b0 ||
        short_err !== 1'b0 || rd_data !== 16'h0000) begin
      errors++;
      $display("FAIL reset: valid=%b fill=%0d ovf=%b serr=%b data=%h expected 0/0/0/0/0000",
               rd_valid, fill, overflow, short_err, rd_data);
    end
    // Pop while empty is ignored
    rd_en = 1'b1;
    @(posedge clk); #1;
    rd_en = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (rd_valid !== 1'b0 || fill !== 5'd0) begin
      errors++;
      $display("FAIL empty_pop: valid=%b fill=%0d expected 0/0", rd_valid, fill);
    end
  endtask

  task automatic test_single_write();
    int lat;
    int s0;
    s0 = short_cnt;
    lat = 0;
    @(posedge clk); #1;
    z80_addr   = 8'hE3;
    z80_data   = 8'h5A;
    z80_iorq_n = 1'b0;
    z80_wr_n   = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (rd_valid === 1'b1 && lat == 0) lat = k;
    end
    z80_iorq_n = 1'b1;
    z80_wr_n   = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (lat != 10) begin
      errors++;
      $display("FAIL latency: got %0d clks expected 10", lat);
    end
    checks++;
    if (fill !== 5'd1) begin
      errors++;
      $display("FAIL single_fill: fill=%0d expected 1", fill);
    end
    pop_check("single_data", 16'hE35A);
    checks++;
    if (rd_valid !== 1'b0 || fill !== 5'd0 || short_cnt != s0) begin
      errors++;
      $display("FAIL single_pop: valid=%b fill=%0d short=%0d expected 0/0/%0d",
               rd_valid, fill, short_cnt, s0);
    end
  endtask

  task automatic test_short_cycle();
    int s0;
    s0 = short_cnt;
    io_write(8'hE1, 8'h11, 4);
    checks++;
    if (short_cnt != s0 + 1 || fill !== 5'd0 || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL short_cycle: pulses=%0d fill=%0d expected pulses=1 fill=0",
               short_cnt - s0, fill);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 17; i++) io_write(8'hE0, 8'(i), 12);
    checks++;
    if (fill !== 5'd16 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_full: fill=%0d ovf=%b expected 16/1", fill, overflow);
    end
    for (int i = 0; i < 16; i++) pop_check("ovf_order", {8'hE0, 8'(i)});
    checks++;
    if (rd_valid !== 1'b0 || fill !== 5'd0 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_drain: valid=%b fill=%0d ovf=%b expected 0/0/1",
               rd_valid, fill, overflow);
    end
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clr: ovf=%b expected 0", overflow);
    end
  endtask

  task automatic test_push_pop_full();
    for (int i = 0; i < 16; i++) io_write(8'hE0, 8'(8'h20 + i), 12);
    // 17th write; rd_en lines up with the SAMPLE cycle (9 edges after assertion)
    @(posedge clk); #1;
    z80_addr   = 8'hE0;
    z80_data   = 8'h99;
    z80_iorq_n = 1'b0;
    z80_wr_n   = 1'b0;
    repeat (9) @(posedge clk);
    #1 rd_en = 1'b1;
    @(posedge clk);
    #1 rd_en = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    z80_iorq_n = 1'b1;
    z80_wr_n   = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (fill !== 5'd16 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL pushpop_full: fill=%0d ovf=%b expected 16/0", fill, overflow);
    end
    for (int i = 1; i < 16; i++) pop_check("pushpop_order", {8'hE0, 8'(8'h20 + i)});
    pop_check("pushpop_last", 16'hE099);
    checks++;
    if (fill !== 5'd0) begin
      errors++;
      $display("FAIL pushpop_drain: fill=%0d expected 0", fill);
    end
  endtask

  task automatic test_long_and_wrap();
    io_write(8'hE7, 8'hC3, 200);
    checks++;
    if (fill !== 5'd1) begin
      errors++;
      $display("FAIL long_cycle: fill=%0d expected 1", fill);
    end
    pop_check("long_data", 16'hE7C3);
    for (int i = 0; i < 40; i++) begin
      io_write(8'hE0 | 8'(i % 16), ~8'(i), 10);
      pop_check("wrap_order", {8'hE0 | 8'(i % 16), ~8'(i)});
    end
    checks++;
    if (fill !== 5'd0 || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL wrap_end: fill=%0d valid=%b expected 0/0", fill, rd_valid);
    end
  endtask

  task automatic test_reset_mid_cycle();
    int s0;
    io_write(8'hE2, 8'h77, 12);
    s0 = short_cnt;
    @(posedge clk); #1;
    z80_addr   = 8'hE4;
    z80_data   = 8'h44;
    z80_iorq_n = 1'b0;
    z80_wr_n   = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    checks++;
    if (rd_valid !== 1'b0 || fill !== 5'd0 || rd_data !== 16'h0000 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: valid=%b fill=%0d data=%h ovf=%b expected 0/0/0000/0",
               rd_valid, fill, rd_data, overflow);
    end
    repeat (20) @(posedge clk);
    #1;
    z80_iorq_n = 1'b1;
    z80_wr_n   = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (fill !== 5'd0 || short_cnt != s0) begin
      errors++;
      $display("FAIL mid_reset_nocap: fill=%0d short=%0d expected 0/%0d",
               fill, short_cnt - s0, 0);
    end
    io_write(8'hE5, 8'h55, 12);
    pop_check("after_reset", 16'hE555);
  endtask

  task automatic test_filter();
    io_write(8'h3F, 8'hA1, 12);
`ifdef IO_PORT_FILTER_EN
    checks++;
    if (fill !== 5'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL filter_reject: fill=%0d ovf=%b expected 0/0", fill, overflow);
    end
`else
    pop_check("nofilter_3f", 16'h3FA1);
`endif
    io_write(8'hEF, 8'hB2, 12);
    checks++;
    if (fill !== 5'd1) begin
      errors++;
      $display("FAIL filter_accept: fill=%0d expected 1", fill);
    end
    pop_check("filter_data", 16'hEFB2);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks     = 0;
    errors     = 0;
    short_cnt  = 0;
    rst_n      = 1'b0;
    z80_iorq_n = 1'b1;
    z80_wr_n   = 1'b1;
    z80_addr   = 8'h00;
    z80_data   = 8'h00;
    rd_en      = 1'b0;
    ovf_clr    = 1'b0;

    test_reset();
    test_single_write();
    test_short_cycle();
    test_overflow();
    test_push_pop_full();
    test_long_and_wrap();
    test_reset_mid_cycle();
    test_filter();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
